// File: rtl/key_tone_gen.sv
// Key-selected square-wave tone generator with thermometer LED bar.
// Define KEY_TONE_DEBOUNCE_EN to enable the shared-counter key debounce.
module key_tone_gen #(
    parameter int unsigned NUM_KEYS   = 5,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned BASE_HALF  = 100000,
    parameter int unsigned STEP_HALF  = 100000,
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key,
    output logic                beep,
    output logic [NUM_KEYS-1:0] led,
    output logic                active,
    output logic [3:0]          tone_idx
);

    localparam longint unsigned MaxHalf =
        64'(BASE_HALF) + 64'(NUM_KEYS - 1) * 64'(STEP_HALF);

    if (NUM_KEYS < 1 || NUM_KEYS > 16) begin : g_bad_num_keys
        $error("key_tone_gen: NUM_KEYS must be in 1..16");
    end
    if (BASE_HALF < 2) begin : g_bad_base_half
        $error("key_tone_gen: BASE_HALF must be >= 2");
    end
    if (DEB_CYCLES < 1) begin : g_bad_deb_cycles
        $error("key_tone_gen: DEB_CYCLES must be >= 1");
    end
    if ((MaxHalf >> CNT_W) != 0) begin : g_bad_cnt_w
        $error("key_tone_gen: longest half-period does not fit in CNT_W bits");
    end

    typedef enum logic [0:0] {StIdle, StTone} state_e;

    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] deb;
    logic                has_sel;
    logic [3:0]          sel_idx;
    state_e              state_q;
    logic [3:0]          idx_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    half;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= key;
            sync2_q <= sync1_q;
        end
    end

`ifdef KEY_TONE_DEBOUNCE_EN
    localparam int unsigned DebW = $clog2(DEB_CYCLES + 1);

    logic [NUM_KEYS-1:0] prev_q, deb_q;
    logic [DebW-1:0]     deb_cnt_q, deb_cnt_d;

    // Counter holds the number of cycles the current sample has been seen, saturating.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        if (sync2_q != prev_q) begin
            deb_cnt_d = DebW'(1);
        end else if (deb_cnt_q != DebW'(DEB_CYCLES)) begin
            deb_cnt_d = deb_cnt_q + DebW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= '1;
            deb_q     <= '0;
            deb_cnt_q <= '0;
        end else begin
            prev_q    <= sync2_q;
            deb_cnt_q <= deb_cnt_d;
            if (deb_cnt_d == DebW'(DEB_CYCLES)) begin
                deb_q <= ~sync2_q;
            end
        end
    end

    assign deb = deb_q;
`else
    assign deb = ~sync2_q;
`endif

    // Lowest-index pressed key wins.
    always_comb begin
        has_sel = 1'b0;
        sel_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (deb[i]) begin
                has_sel = 1'b1;
                sel_idx = 4'(i);
            end
        end
    end

    assign half = CNT_W'(BASE_HALF) + CNT_W'(idx_q) * CNT_W'(STEP_HALF);

    function automatic logic [NUM_KEYS-1:0] therm(input logic [3:0] i);
        for (int k = 0; k < NUM_KEYS; k++) begin
            therm[k] = (4'(k) <= i);
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            cnt_q    <= '0;
            beep     <= 1'b0;
            led      <= '0;
            active   <= 1'b0;
            tone_idx <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (has_sel) begin
                        state_q  <= StTone;
                        idx_q    <= sel_idx;
                        cnt_q    <= '0;
                        active   <= 1'b1;
                        led      <= therm(sel_idx);
                        tone_idx <= sel_idx;
                    end
                end
                StTone: begin
                    if (!has_sel) begin
                        state_q  <= StIdle;
                        idx_q    <= '0;
                        cnt_q    <= '0;
                        beep     <= 1'b0;
                        active   <= 1'b0;
                        led      <= '0;
                        tone_idx <= '0;
                    end else if (sel_idx != idx_q) begin
                        // Tone change beats a coinciding terminal count: restart, keep level.
                        idx_q    <= sel_idx;
                        cnt_q    <= '0;
                        led      <= therm(sel_idx);
                        tone_idx <= sel_idx;
                    end else if (cnt_q == half - CNT_W'(1)) begin
                        beep  <= ~beep;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_key_tone_gen.sv
// Directed self-checking bench for key_tone_gen (NUM_KEYS=5, BASE=4, STEP=2, DEB=8).
module tb_key_tone_gen;

`ifdef KEY_TONE_DEBOUNCE_EN
    localparam int Lat = 11;
`else
    localparam int Lat = 3;
`endif

    logic       clk;
    logic       rst_n;
    logic [4:0] key;
    logic       beep;
    logic [4:0] led;
    logic       active;
    logic [3:0] tone_idx;

    logic [10:0] obs;
    logic [10:0] exp_v;
    int          n_cmp;
    int          n_err;

    localparam logic [10:0] Idle = 11'b0_0000_00000_0;

    key_tone_gen #(
        .NUM_KEYS  (5),
        .CNT_W     (32),
        .BASE_HALF (4),
        .STEP_HALF (2),
        .DEB_CYCLES(8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .key     (key),
        .beep    (beep),
        .led     (led),
        .active  (active),
        .tone_idx(tone_idx)
    );

    assign obs = {active, tone_idx, led, beep};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        key   = 5'b11111;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== Idle) begin
            n_err++;
            $display("FAIL reset_async: got %b want %b", obs, Idle);
        end
        tick(2);
        rst_n = 1'b1;
        tick(Lat + 3);
        n_cmp++;
        if (obs !== Idle) begin
            n_err++;
            $display("FAIL reset_no_keys_idle: got %b want %b", obs, Idle);
        end
    endtask

    task automatic test_key0();
        do_reset();
        key = 5'b11110;
        tick(Lat - 1);
        n_cmp++;
        if (obs !== Idle) begin
            n_err++;
            $display("FAIL key0_before_latency: got %b want %b", obs, Idle);
        end
        tick(1);
        exp_v = 11'b1_0000_00001_0;
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL key0_entry: got %b want %b", obs, exp_v);
        end
        tick(3);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL key0_low_half: got %b want %b", obs, exp_v);
        end
        tick(1);
        exp_v = 11'b1_0000_00001_1;
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL key0_rise: got %b want %b", obs, exp_v);
        end
        tick(3);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL key0_high_half: got %b want %b", obs, exp_v);
        end
        tick(1);
        exp_v = 11'b1_0000_00001_0;
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL key0_fall: got %b want %b", obs, exp_v);
        end
    endtask

    task automatic test_key2();
        do_reset();
        key = 5'b11011;
        tick(Lat);
        exp_v = 11'b1_0010_00111_0;
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL key2_entry: got %b want %b", obs, exp_v);
        end
        tick(7);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL key2_low_half: got %b want %b", obs, exp_v);
        end
        tick(1);
        exp_v = 11'b1_0010_00111_1;
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL key2_rise: got %b want %b", obs, exp_v);
        end
        tick(7);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL key2_high_half: got %b want %b", obs, exp_v);
        end
        tick(1);
        exp_v = 11'b1_0010_00111_0;
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL key2_fall: got %b want %b", obs, exp_v);
        end
        key = 5'b11111;
        tick(Lat);
        n_cmp++;
        if (obs !== Idle) begin
            n_err++;
            $display("FAIL key2_release_idle: got %b want %b", obs, Idle);
        end
    endtask

    task automatic test_priority();
        do_reset();
        key = 5'b10110;
        tick(Lat);
        exp_v = 11'b1_0000_00001_0;
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL prio_entry: got %b want %b", obs, exp_v);
        end
        tick(4);
        exp_v = 11'b1_0000_00001_1;
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL prio_rise: got %b want %b", obs, exp_v);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        key = 5'b11101;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
`ifdef KEY_TONE_DEBOUNCE_EN
            exp_v = Idle;
`else
            exp_v = (k >= 3 && k <= 7) ? 11'b1_0001_00011_0 : Idle;
`endif
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL glitch_cycle%0d: got %b want %b", k, obs, exp_v);
            end
            if (k == 5) key = 5'b11111;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        key = 5'b11101;
        tick(Lat);
        exp_v = 11'b1_0001_00011_0;
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL switch_key1_entry: got %b want %b", obs, exp_v);
        end
        tick(6);
        exp_v = 11'b1_0001_00011_1;
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL switch_key1_rise: got %b want %b", obs, exp_v);
        end
        tick(3);
        key = 5'b01111;
        tick(Lat);
        exp_v = 11'b1_0100_11111_1;
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL switch_key4_entry: got %b want %b", obs, exp_v);
        end
        tick(11);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL switch_key4_hold: got %b want %b", obs, exp_v);
        end
        tick(1);
        exp_v = 11'b1_0100_11111_0;
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL switch_key4_toggle: got %b want %b", obs, exp_v);
        end
    endtask

    task automatic test_reset_mid_tone();
        do_reset();
        key = 5'b11110;
        tick(Lat + 5);
        exp_v = 11'b1_0000_00001_1;
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL midrst_pre: got %b want %b", obs, exp_v);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== Idle) begin
            n_err++;
            $display("FAIL midrst_async_silence: got %b want %b", obs, Idle);
        end
        tick(2);
        rst_n = 1'b1;
        tick(Lat - 1);
        n_cmp++;
        if (obs !== Idle) begin
            n_err++;
            $display("FAIL midrst_relatency: got %b want %b", obs, Idle);
        end
        tick(1);
        exp_v = 11'b1_0000_00001_0;
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL midrst_resume: got %b want %b", obs, exp_v);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b1;
        key   = 5'b11111;
        test_reset();
        test_key0();
        test_key2();
        test_priority();
        test_glitch();
        test_back_to_back();
        test_reset_mid_tone();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
